// File: rtl/syn_fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// syn_fifo_wr_arbiter_if : requester-side and FIFO-write-side bundle
// Revision 1.0
// ============================================================================
interface syn_fifo_wr_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_ENTRIES = 16
);
  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_LVL_W = $clog2(FIFO_ENTRIES) + 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_rd_en;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          grant_valid;
  logic [c_ID_W-1:0]             grant_id;
  logic [c_LVL_W-1:0]            level;

  // Requesters and the FIFO pop observer sit on the master side.
  modport master (
    output req_valid, req_data, fifo_rd_en,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, level
  );

  modport slave (
    input  req_valid, req_data, fifo_rd_en,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id, level
  );
endinterface
`default_nettype wire

// File: rtl/syn_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// syn_fifo_wr_arbiter : round-robin burst arbiter for one FIFO write port
// Revision 1.0
// ============================================================================
module syn_fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_ENTRIES = 16,
  parameter int MAX_BURST    = 4
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  syn_fifo_wr_arbiter_if.slave bus
);
  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_LVL_W = $clog2(FIFO_ENTRIES) + 1;
  localparam int c_CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_GRANT = 1'b1;

  localparam logic [c_LVL_W-1:0] c_FULL      = c_LVL_W'(FIFO_ENTRIES);
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);
  localparam logic [c_ID_W-1:0]  c_LAST_REQ  = c_ID_W'(NUM_REQ - 1);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [c_ID_W-1:0]     r_grant_id;
  logic [c_ID_W-1:0]     r_last_grant;
  logic [c_ID_W-1:0]     w_rr_sel;
  logic [c_ID_W-1:0]     w_scan_idx;
  logic [c_CNT_W-1:0]    r_beat_cnt;
  logic [c_LVL_W-1:0]    r_level;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  w_any_req;
  logic                  w_own_valid;
  logic                  w_has_room;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_start;

  logic [DATA_WIDTH-1:0] w_req_beat [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_req_beat[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan downward so the smallest offset past last_grant is the final winner.
  always_comb begin
    w_rr_sel   = r_last_grant;
    w_scan_idx = r_last_grant;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_scan_idx = c_ID_W'((int'(r_last_grant) + i) % NUM_REQ);
      if (bus.req_valid[w_scan_idx]) begin
        w_rr_sel = w_scan_idx;
      end
    end
  end

  assign w_any_req   = |bus.req_valid;
  assign w_own_valid = bus.req_valid[r_grant_id];
  assign w_has_room  = (r_level < c_FULL);
  assign w_accept    = (r_state == c_ST_GRANT) && w_own_valid && w_has_room;
  assign w_pop       = bus.fifo_rd_en && (r_level != '0);
  assign w_start     = (r_state == c_ST_IDLE) && w_any_req;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = c_ST_GRANT;
        end
      end
      c_ST_GRANT: begin
        if (!w_own_valid || (w_accept && (r_beat_cnt == c_LAST_BEAT))) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Ready looks only at the registered level; a same-cycle pop cannot raise it.
  always_comb begin
    bus.req_ready   = '0;
    bus.grant_valid = 1'b0;
    if (r_state == c_ST_GRANT) begin
      bus.grant_valid            = 1'b1;
      bus.req_ready[r_grant_id]  = w_has_room;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_grant_id   <= '0;
      r_last_grant <= c_LAST_REQ;
      r_beat_cnt   <= '0;
      r_level      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_data  <= w_req_beat[r_grant_id];
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_start) begin
        r_grant_id   <= w_rr_sel;
        r_last_grant <= w_rr_sel;
        r_beat_cnt   <= '0;
      end
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.grant_id     = r_grant_id;
  assign bus.level        = r_level;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_syn_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_syn_fifo_wr_arbiter : directed bench with a cycle model and literal checks
// Revision 1.0
// ============================================================================
module tb_syn_fifo_wr_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int DATA_WIDTH   = 8;
  localparam int FIFO_ENTRIES = 16;
  localparam int MAX_BURST    = 4;
  localparam int QD           = 128;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  syn_fifo_wr_arbiter_if #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .FIFO_ENTRIES(FIFO_ENTRIES)
  ) bus ();

  syn_fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
    .FIFO_ENTRIES(FIFO_ENTRIES), .MAX_BURST(MAX_BURST)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-requester beat sources: head advances when a handshake was seen.
  logic [DATA_WIDTH-1:0] mem [NUM_REQ][QD];
  int head [NUM_REQ] = '{default: 0};
  int tail [NUM_REQ] = '{default: 0};
  logic [NUM_REQ-1:0] acc_seen = '0;

  task automatic push(input int r, input logic [DATA_WIDTH-1:0] d);
    mem[r][tail[r]] = d;
    tail[r]++;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    forever begin
      @(posedge sys_clk);
      #2;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_seen[i]) head[i]++;
        if (head[i] < tail[i]) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][head[i]];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Behavioural model: owner index (-1 = none), occupancy and write pipe.
  int m_owner, m_last, m_beats, m_level, m_gid;
  logic m_wr_en;
  logic [DATA_WIDTH-1:0] m_wr_data;

  initial begin
    int k;
    bit acc, pop, found;
    m_owner = -1; m_last = NUM_REQ - 1; m_beats = 0; m_level = 0; m_gid = 0;
    m_wr_en = 1'b0; m_wr_data = '0;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        m_owner = -1; m_last = NUM_REQ - 1; m_beats = 0; m_level = 0; m_gid = 0;
        m_wr_en = 1'b0; m_wr_data = '0;
      end else begin
        acc = 1'b0;
        if (m_owner >= 0) acc = bus.req_valid[m_owner] && (m_level < FIFO_ENTRIES);
        pop = bus.fifo_rd_en && (m_level > 0);
        m_wr_en = acc;
        if (acc) m_wr_data = bus.req_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
        m_level = m_level + int'(acc) - int'(pop);
        if (m_owner < 0) begin
          found = 1'b0;
          for (int s = 1; s <= NUM_REQ; s++) begin
            k = (m_last + s) % NUM_REQ;
            if (!found && bus.req_valid[k]) begin
              found = 1'b1; m_owner = k; m_gid = k; m_beats = 0;
            end
          end
          if (found) m_last = m_owner;
        end else if (acc) begin
          m_beats++;
          if (m_beats == MAX_BURST) m_owner = -1;
        end else if (!bus.req_valid[m_owner]) begin
          m_owner = -1;
        end
      end
    end
  end

  // Per-cycle compare plus logs of writes and grant starts.
  int cyc = 0;
  logic [DATA_WIDTH-1:0] wlog[$];
  int wcyc[$];
  int glog[$];
  int gcyc[$];
  logic prev_gv = 1'b0;

  initial begin
    logic [NUM_REQ-1:0] er;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!sys_rst_n) begin
        acc_seen = '0;
        prev_gv  = 1'b0;
      end else begin
        acc_seen = bus.req_valid & bus.req_ready;
        er = '0;
        if (m_owner >= 0 && m_level < FIFO_ENTRIES) er[m_owner] = 1'b1;
        chk("grant_valid", bus.grant_valid, m_owner >= 0);
        chk("grant_id", bus.grant_id, m_gid);
        chk("req_ready", bus.req_ready, er);
        chk("ready_onehot0", $onehot0(bus.req_ready), 1);
        chk("level", bus.level, m_level);
        chk("fifo_wr_en", bus.fifo_wr_en, m_wr_en);
        chk("fifo_wr_data", bus.fifo_wr_data, m_wr_data);
        if (bus.fifo_wr_en) begin
          wlog.push_back(bus.fifo_wr_data);
          wcyc.push_back(cyc);
        end
        if (bus.grant_valid && !prev_gv) begin
          glog.push_back(int'(bus.grant_id));
          gcyc.push_back(cyc);
        end
        prev_gv = bus.grant_valid;
      end
    end
  end

  function automatic logic [31:0] wl(input int i);
    return (i < wlog.size()) ? 32'(wlog[i]) : 'x;
  endfunction
  function automatic logic [31:0] wc(input int i);
    return (i < wcyc.size()) ? wcyc[i] : 'x;
  endfunction
  function automatic logic [31:0] gl(input int i);
    return (i < glog.size()) ? glog[i] : 'x;
  endfunction
  function automatic logic [31:0] gc(input int i);
    return (i < gcyc.size()) ? gcyc[i] : 'x;
  endfunction

  task automatic nwait(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); glog.delete(); gcyc.delete();
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < NUM_REQ; i++) tail[i] = head[i];
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    bus.fifo_rd_en = 1'b0;
    nwait(3);
    sys_rst_n = 1'b1;
    chk("rst_level", bus.level, 0);
    chk("rst_grant_valid", bus.grant_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);

    // Single requester burst of three beats, then release.
    clear_logs();
    push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
    nwait(12);
    chk("t1_grants", glog.size(), 1);
    chk("t1_gid", gl(0), 2);
    chk("t1_nwr", wlog.size(), 3);
    chk("t1_d0", wl(0), 8'h11);
    chk("t1_d1", wl(1), 8'h22);
    chk("t1_d2", wl(2), 8'h33);
    chk("t1_back_to_back", wc(2) - wc(0), 2);
    chk("t1_level", bus.level, 3);
    chk("t1_idle", bus.grant_valid, 0);

    // Fairness with all requesters busy and the FIFO drained every cycle.
    do_reset();
    clear_logs();
    bus.fifo_rd_en = 1'b1;
    for (int r = 0; r < NUM_REQ; r++)
      for (int b = 0; b < 8; b++) push(r, 8'(r*16 + b));
    nwait(60);
    bus.fifo_rd_en = 1'b0;
    for (int j = 0; j < 5; j++) chk("t2_order", gl(j), order[j]);
    for (int j = 1; j < 5; j++) chk("t2_grant_spacing", gc(j) - gc(j-1), 5);
    for (int j = 0; j < 20; j++)
      chk("t2_wdata", wl(j), order[j/4]*16 + ((j/4 == 4) ? 4 : 0) + j%4);
    chk("t2_total_writes", wlog.size(), 32);
    chk("t2_level", bus.level, 0);

    // Backpressure at a full FIFO, then a single pop frees one slot.
    clear_logs();
    for (int b = 0; b < 20; b++) push(0, 8'(8'h80 + b));
    nwait(40);
    chk("t3_level_full", bus.level, 16);
    chk("t3_nwr16", wlog.size(), 16);
    chk("t3_last16", wl(15), 8'h8F);
    chk("t3_ready_low", bus.req_ready, 4'b0000);
    chk("t3_still_granted", bus.grant_valid, 1);
    chk("t3_gid", bus.grant_id, 0);
    bus.fifo_rd_en = 1'b1;
    nwait(1);
    bus.fifo_rd_en = 1'b0;
    chk("t3_level_15", bus.level, 15);
    chk("t3_ready_back", bus.req_ready, 4'b0001);
    nwait(8);
    chk("t3_level_refull", bus.level, 16);
    chk("t3_nwr17", wlog.size(), 17);
    chk("t3_d17", wl(16), 8'h90);

    // Pop at empty is ignored; accept plus pop at level 8 holds level.
    do_reset();
    bus.fifo_rd_en = 1'b1;
    nwait(1);
    bus.fifo_rd_en = 1'b0;
    chk("t4_empty_pop", bus.level, 0);
    for (int b = 0; b < 8; b++) push(1, 8'(8'h40 + b));
    nwait(20);
    chk("t4_level8", bus.level, 8);
    chk("t4_idle", bus.grant_valid, 0);
    push(1, 8'h55);
    nwait(2);
    chk("t4_ready", bus.req_ready, 4'b0010);
    bus.fifo_rd_en = 1'b1;
    nwait(1);
    bus.fifo_rd_en = 1'b0;
    chk("t4_level_hold", bus.level, 8);
    chk("t4_wr_en", bus.fifo_wr_en, 1);
    chk("t4_wr_data", bus.fifo_wr_data, 8'h55);

    // Pointer wrap: last owner 3, then 0 and 2 compete.
    push(3, 8'h77);
    nwait(8);
    chk("t5_level9", bus.level, 9);
    clear_logs();
    push(0, 8'hA0); push(0, 8'hA1); push(2, 8'hC0); push(2, 8'hC1);
    nwait(16);
    chk("t5_grants", glog.size(), 2);
    chk("t5_first", gl(0), 0);
    chk("t5_second", gl(1), 2);
    chk("t5_d0", wl(0), 8'hA0);
    chk("t5_d2", wl(2), 8'hC0);
    chk("t5_level13", bus.level, 13);

    // Asynchronous reset two beats into a burst.
    for (int b = 0; b < 4; b++) push(1, 8'(8'hB0 + b));
    nwait(4);
    chk("t6_pre_level", bus.level, 15);
    chk("t6_pre_wr", bus.fifo_wr_en, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("t6_req_ready", bus.req_ready, 0);
    chk("t6_wr_en", bus.fifo_wr_en, 0);
    chk("t6_wr_data", bus.fifo_wr_data, 0);
    chk("t6_grant_valid", bus.grant_valid, 0);
    chk("t6_grant_id", bus.grant_id, 0);
    chk("t6_level", bus.level, 0);
    @(negedge sys_clk);
    for (int i = 0; i < NUM_REQ; i++) tail[i] = head[i];
    clear_logs();
    push(1, 8'hD1); push(0, 8'hD0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    nwait(12);
    chk("t6_grants", glog.size(), 2);
    chk("t6_first", gl(0), 0);
    chk("t6_second", gl(1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
